// File: rtl/detect_stream_ctrl.sv
// Run controller for the sequence-detector datapath: serializes parallel
// samples MSB-first onto the detector stream and counts detections per run.
module detect_stream_ctrl #(
    parameter int SAMPLE_WIDTH = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    input  logic                    sample_last,
    output logic                    sample_ready,
    output logic                    data_serial,
    output logic                    data_valid,
    input  logic                    moore_det,
    input  logic                    mealy_det,
    output logic [COUNT_WIDTH-1:0]  moore_count,
    output logic [COUNT_WIDTH-1:0]  mealy_count,
    output logic                    busy,
    output logic                    done,
    output logic                    mismatch
);

    localparam int IW = $clog2(SAMPLE_WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLE_WIDTH - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [SAMPLE_WIDTH-1:0] shreg;
    logic [IW-1:0]           idx;
    logic                    last_q;
    logic                    last_bit;
    logic                    load;
    logic                    run_start;
    logic                    moore_win;

    assign last_bit  = (idx == LAST_IDX);
    assign run_start = (state == IDLE) && start;
    assign moore_win = state inside {LOAD, SHIFT, DRAIN};

    // Outputs depend only on registered state; ready may reopen on the
    // final bit so back-to-back samples stream without a gap.
    assign sample_ready = (state == LOAD) ||
                          ((state == SHIFT) && last_bit && !last_q);
    assign load         = sample_valid && sample_ready;
    assign data_valid   = (state == SHIFT);
    assign data_serial  = data_valid && shreg[SAMPLE_WIDTH-1];
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = LOAD;
            LOAD:  if (sample_valid) state_nxt = SHIFT;
            SHIFT: begin
                if (last_bit) begin
                    if (last_q) begin
                        state_nxt = DRAIN;
                    end else if (!sample_valid) begin
                        state_nxt = LOAD;
                    end
                end
            end
            DRAIN: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg  <= '0;
            idx    <= '0;
            last_q <= 1'b0;
        end else if (load) begin
            shreg  <= sample_in;
            idx    <= '0;
            last_q <= sample_last;
        end else if (state == SHIFT) begin
            shreg <= shreg << 1;
            idx   <= idx + IW'(1);
        end
    end

    // DRAIN still counts Moore so the pulse from the final bit is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            moore_count <= '0;
            mealy_count <= '0;
            mismatch    <= 1'b0;
        end else if (run_start) begin
            moore_count <= '0;
            mealy_count <= '0;
            mismatch    <= 1'b0;
        end else begin
            if (mealy_det && data_valid && (mealy_count != CNT_MAX)) begin
                mealy_count <= mealy_count + 1'b1;
            end
            if (moore_det && moore_win && (moore_count != CNT_MAX)) begin
                moore_count <= moore_count + 1'b1;
            end
            if (state == DONE) begin
                mismatch <= (moore_count != mealy_count);
            end
        end
    end

endmodule

// File: tb/tb_detect_stream_ctrl.sv
// Directed bench for detect_stream_ctrl; a second instance with narrow
// counters shares the stimulus to exercise saturation.
module tb_detect_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  sample_in;
    logic        sample_valid;
    logic        sample_last;
    logic        moore_det;
    logic        mealy_det;

    logic        sample_ready, data_serial, data_valid;
    logic [15:0] moore_count, mealy_count;
    logic        busy, done, mismatch;

    logic        s_ready, s_serial, s_valid;
    logic [1:0]  s_moore, s_mealy;
    logic        s_busy, s_done, s_mismatch;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    detect_stream_ctrl #(.SAMPLE_WIDTH(4), .COUNT_WIDTH(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_last(sample_last), .sample_ready(sample_ready),
        .data_serial(data_serial), .data_valid(data_valid),
        .moore_det(moore_det), .mealy_det(mealy_det),
        .moore_count(moore_count), .mealy_count(mealy_count),
        .busy(busy), .done(done), .mismatch(mismatch)
    );

    detect_stream_ctrl #(.SAMPLE_WIDTH(4), .COUNT_WIDTH(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .start(start),
        .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_last(sample_last), .sample_ready(s_ready),
        .data_serial(s_serial), .data_valid(s_valid),
        .moore_det(moore_det), .mealy_det(mealy_det),
        .moore_count(s_moore), .mealy_count(s_mealy),
        .busy(s_busy), .done(s_done), .mismatch(s_mismatch)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] pat;
    int         gap;
    logic       saw_done;

    initial begin
        reset_n = 1'b0; start = 1'b0; sample_in = '0;
        sample_valid = 1'b0; sample_last = 1'b0;
        moore_det = 1'b0; mealy_det = 1'b0;

        // reset
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_ready", sample_ready, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_ser", data_serial, 0);
        chk("rst_done", done, 0);
        chk("rst_mis", mismatch, 0);
        chk("rst_cnt", {moore_count, mealy_count}, 0);
        reset_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_busy", busy, 1);
        chk("load_ready", sample_ready, 1);
        chk("load_dv", data_valid, 0);

        // single sample 1011
        pat = 8'b1011_0000;
        sample_in = 4'b1011; sample_valid = 1'b1; sample_last = 1'b1;
        tick();
        sample_valid = 1'b0; sample_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("single_dv", data_valid, 1);
            chk("single_bit", data_serial, pat[7-i]);
            chk("single_rdy", sample_ready, 0);
            tick();
        end
        chk("single_drain_dv", data_valid, 0);
        chk("single_drain_done", done, 0);
        chk("single_drain_busy", busy, 1);
        tick();
        chk("single_done", done, 1);
        tick();
        chk("single_done_off", done, 0);
        chk("single_idle", busy, 0);
        chk("single_mis", mismatch, 0);

        // back-to-back A then 5
        start = 1'b1; tick(); start = 1'b0;
        pat = 8'b1010_0101;
        sample_in = 4'hA; sample_valid = 1'b1; sample_last = 1'b0;
        tick();
        sample_in = 4'h5; sample_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) sample_valid = 1'b0;
            chk("b2b_dv", data_valid, 1);
            chk("b2b_bit", data_serial, pat[7-i]);
            if (i == 3) chk("b2b_rdy_last", sample_ready, 1);
            if (i == 7) chk("b2b_rdy_final", sample_ready, 0);
            tick();
        end
        chk("b2b_drain", data_valid, 0);
        tick();
        chk("b2b_done", done, 1);
        tick();

        // 3-cycle valid gap between nibbles
        start = 1'b1; tick(); start = 1'b0;
        sample_in = 4'hA; sample_valid = 1'b1; sample_last = 1'b0;
        tick();
        sample_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("gap_bitA", data_serial, pat[7-i]);
            tick();
        end
        gap = 0;
        while (!data_valid && gap < 10) begin
            gap++;
            if (gap == 3) begin
                sample_in = 4'h5; sample_valid = 1'b1; sample_last = 1'b1;
            end
            tick();
        end
        chk("gap_len", gap, 3);
        sample_valid = 1'b0; sample_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("gap_dv", data_valid, 1);
            chk("gap_bit5", data_serial, pat[3-i]);
            tick();
        end
        tick();
        chk("gap_done", done, 1);
        tick();

        // Moore pulse in IDLE is ignored
        moore_det = 1'b1; tick(); moore_det = 1'b0;
        chk("idle_moore", moore_count, 0);

        // counting 3/3: mealy in DRAIN must not count
        start = 1'b1; tick(); start = 1'b0;
        sample_in = 4'hF; sample_valid = 1'b1; sample_last = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mealy_det = (i < 3);
            moore_det = (i == 1 || i == 3);
            tick();
        end
        mealy_det = 1'b1; moore_det = 1'b1;
        tick();
        mealy_det = 1'b0; moore_det = 1'b0;
        chk("cnt_done", done, 1);
        chk("cnt_moore", moore_count, 3);
        chk("cnt_mealy", mealy_count, 3);
        tick();
        chk("cnt_mis", mismatch, 0);
        chk("cnt_hold", {moore_count, mealy_count}, {16'd3, 16'd3});

        // dropped mealy pulse 3/2
        start = 1'b1; tick(); start = 1'b0;
        chk("clr_cnt", {moore_count, mealy_count}, 0);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mealy_det = (i < 2);
            moore_det = (i == 1 || i == 3);
            tick();
        end
        mealy_det = 1'b0; moore_det = 1'b1;
        tick();
        moore_det = 1'b0;
        tick();
        chk("drop_moore", moore_count, 3);
        chk("drop_mealy", mealy_count, 2);
        chk("drop_mis", mismatch, 1);
        chk("drop_mis_sat", s_mismatch, 1);

        // saturation: 5 mealy pulses over two nibbles
        start = 1'b1; tick(); start = 1'b0;
        sample_in = 4'hA; sample_valid = 1'b1; sample_last = 1'b0;
        tick();
        sample_in = 4'h5; sample_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) sample_valid = 1'b0;
            mealy_det = (i < 5);
            tick();
        end
        mealy_det = 1'b0;
        tick(); tick();
        chk("sat_wide", mealy_count, 5);
        chk("sat_narrow", s_mealy, 3);
        chk("sat_mis", s_mismatch, 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("sat_clr_cnt", {s_moore, s_mealy}, 0);
        chk("sat_clr_mis", s_mismatch, 0);

        // reset in the second bit of SHIFT
        sample_in = 4'hC; sample_valid = 1'b1; sample_last = 1'b1;
        tick();
        sample_valid = 1'b0;
        mealy_det = 1'b1; moore_det = 1'b1;
        tick();
        mealy_det = 1'b0; moore_det = 1'b0;
        chk("mid_bit1", data_serial, 1);
        chk("mid_cnt", {moore_count, mealy_count}, {16'd1, 16'd1});
        reset_n = 1'b0;
        #1;
        chk("mid_dv", data_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_cnt_rst", {moore_count, mealy_count}, 0);
        tick();
        reset_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            saw_done = saw_done | done | busy;
            tick();
        end
        chk("mid_no_done", saw_done, 0);

        // start during SHIFT is ignored
        start = 1'b1; tick(); start = 1'b0;
        pat = 8'b1001_0000;
        sample_in = 4'b1001; sample_valid = 1'b1; sample_last = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mealy_det = (i == 0);
            start = (i == 1);
            chk("ign_bit", data_serial, pat[7-i]);
            chk("ign_dv", data_valid, 1);
            tick();
        end
        mealy_det = 1'b0; start = 1'b0;
        chk("ign_drain", data_valid, 0);
        tick();
        chk("ign_done", done, 1);
        tick();
        chk("ign_idle", busy, 0);
        chk("ign_cnt", {moore_count, mealy_count}, {16'd0, 16'd1});
        chk("ign_mis", mismatch, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
